// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the icache, dcache, memory-side and status signals
// of the memory arbiter.
//   slave  modport: the arbiter's view. It takes in the requester commands and
//                   the memory responses. It drives out the per-requester
//                   responses/returns, the memory request and the status.
//   master modport: the environment's view, with every direction reversed.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  // icache side
  logic [1:0]      ic_command;
  logic [XLEN-1:0] ic_addr;
  logic [3:0]      ic_response;
  logic [63:0]     ic_rdata;
  logic [3:0]      ic_rtag;
  // dcache side
  logic [1:0]      dc_command;
  logic [XLEN-1:0] dc_addr;
  logic [63:0]     dc_wdata;
  logic [1:0]      dc_size;
  logic [3:0]      dc_response;
  logic [63:0]     dc_rdata;
  logic [3:0]      dc_rtag;
  // memory side
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [1:0]      proc2mem_size;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;
  // status
  logic [4:0]      ic_outstanding;
  logic [4:0]      dc_outstanding;
  logic            spurious_tag;

  modport slave (
    input  ic_command, ic_addr, dc_command, dc_addr, dc_wdata, dc_size,
           mem2proc_response, mem2proc_data, mem2proc_tag,
    output ic_response, ic_rdata, ic_rtag, dc_response, dc_rdata, dc_rtag,
           proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
           ic_outstanding, dc_outstanding, spurious_tag
  );

  modport master (
    output ic_command, ic_addr, dc_command, dc_addr, dc_wdata, dc_size,
           mem2proc_response, mem2proc_data, mem2proc_tag,
    input  ic_response, ic_rdata, ic_rtag, dc_response, dc_rdata, dc_rtag,
           proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
           ic_outstanding, dc_outstanding, spurious_tag
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an icache and a dcache.
//   clock, reset_n : sole clock and asynchronous active-low reset
//   bus (slave)    : icache/dcache requests and returns, the memory request
//                    and response, and the status outputs
//                    (ic/dc_outstanding, sticky spurious_tag)
// The arbiter prefers the dcache. The icache wins once it has been refused
// STARVE_LIMIT times in a row. A 16-entry owner table, indexed by memory tag,
// routes each data return to the requester that issued the load.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clock,
  input logic           reset_n,
  mem_arbiter_if.slave  bus
);
  localparam logic [1:0] CMD_NONE   = 2'd0;
  localparam logic [1:0] CMD_LOAD   = 2'd1;
  localparam logic [1:0] CMD_STORE  = 2'd2;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [2:0] STARVE_MAX = 3'd7;

  // Number of valid table entries that belong to one owner (0=icache, 1=dcache).
  function automatic logic [4:0] count_owned(input logic [15:0] valid,
                                             input logic [15:0] owner,
                                             input logic        want_dc);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (valid[i] && (owner[i] == want_dc)) n = n + 5'd1;
      else                                   n = n;
    end
    return n;
  endfunction

  logic [15:0] valid_q, valid_d;
  logic [15:0] owner_q, owner_d;
  logic [2:0]  starve_q, starve_d;
  logic [4:0]  ic_out_q, ic_out_d;
  logic [4:0]  dc_out_q, dc_out_d;
  logic        spurious_q, spurious_d;

  logic ic_req, dc_req, grant_ic, grant_dc, accepted, alloc;
  logic ret_live, ret_owner, ret_spurious;

  // Arbitration and memory-side forwarding. An icache STORE counts as no request.
  always_comb begin
    ic_req   = (bus.ic_command == CMD_LOAD);
    dc_req   = (bus.dc_command == CMD_LOAD) || (bus.dc_command == CMD_STORE);
    grant_ic = ic_req && (!dc_req || (int'(starve_q) >= STARVE_LIMIT));
    grant_dc = dc_req && !grant_ic;
    accepted = (bus.mem2proc_response != 4'd0);
    alloc    = accepted && (grant_ic || (grant_dc && (bus.dc_command == CMD_LOAD)));
    case ({grant_dc, grant_ic})
      2'b10: begin
        bus.proc2mem_command = bus.dc_command;
        bus.proc2mem_addr    = bus.dc_addr;
        bus.proc2mem_data    = bus.dc_wdata;
        bus.proc2mem_size    = bus.dc_size;
      end
      2'b01: begin
        bus.proc2mem_command = CMD_LOAD;
        bus.proc2mem_addr    = bus.ic_addr;
        bus.proc2mem_data    = 64'd0;
        bus.proc2mem_size    = SIZE_WORD;
      end
      default: begin
        bus.proc2mem_command = CMD_NONE;
        bus.proc2mem_addr    = {XLEN{1'b0}};
        bus.proc2mem_data    = 64'd0;
        bus.proc2mem_size    = 2'd0;
      end
    endcase
    bus.ic_response = grant_ic ? bus.mem2proc_response : 4'd0;
    bus.dc_response = grant_dc ? bus.mem2proc_response : 4'd0;
  end

  // Return routing. This uses the table as it stood before this edge, so a
  // tag returned and re-allocated in the same cycle goes to its old owner.
  always_comb begin
    ret_live     = (bus.mem2proc_tag != 4'd0) && valid_q[bus.mem2proc_tag];
    ret_owner    = owner_q[bus.mem2proc_tag];
    ret_spurious = (bus.mem2proc_tag != 4'd0) && !valid_q[bus.mem2proc_tag];
    if (ret_live && !ret_owner) begin
      bus.ic_rtag  = bus.mem2proc_tag;
      bus.ic_rdata = bus.mem2proc_data;
    end else begin
      bus.ic_rtag  = 4'd0;
      bus.ic_rdata = 64'd0;
    end
    if (ret_live && ret_owner) begin
      bus.dc_rtag  = bus.mem2proc_tag;
      bus.dc_rdata = bus.mem2proc_data;
    end else begin
      bus.dc_rtag  = 4'd0;
      bus.dc_rdata = 64'd0;
    end
    bus.ic_outstanding = ic_out_q;
    bus.dc_outstanding = dc_out_q;
    bus.spurious_tag   = spurious_q;
  end

  // Next state. The return clears its entry first, then the allocation
  // overrides it. The counters are recounted from the new table, so an
  // allocation and a return for the same owner cancel out.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    if (ret_live) valid_d[bus.mem2proc_tag] = 1'b0;
    else          valid_d = valid_d;
    if (alloc) begin
      valid_d[bus.mem2proc_response] = 1'b1;
      owner_d[bus.mem2proc_response] = grant_dc;
    end else begin
      owner_d = owner_d;
    end
    if (!ic_req)                    starve_d = starve_q;
    else if (grant_ic && accepted)  starve_d = 3'd0;
    else if (starve_q == STARVE_MAX) starve_d = starve_q;
    else                            starve_d = starve_q + 3'd1;
    spurious_d = spurious_q | ret_spurious;
    ic_out_d   = count_owned(valid_d, owner_d, 1'b0);
    dc_out_d   = count_owned(valid_d, owner_d, 1'b1);
  end

  // State registers, cleared asynchronously by reset_n.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 16'd0;
      owner_q    <= 16'd0;
      starve_q   <= 3'd0;
      ic_out_q   <= 5'd0;
      dc_out_q   <= 5'd0;
      spurious_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      ic_out_q   <= ic_out_d;
      dc_out_q   <= dc_out_d;
      spurious_q <= spurious_d;
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive icache denials before icache gets priority.
REQ-003 SHALL have ports clock (in, 1, sole clock) and reset_n (in, 1, asynchronous active-low reset).
REQ-004 SHALL have icache ports: ic_command in 2 (0=NONE, 1=LOAD, 2=STORE); ic_addr in XLEN; ic_response out 4; ic_rdata out 64; ic_rtag out 4.
REQ-005 SHALL have dcache ports: dc_command in 2; dc_addr in XLEN; dc_wdata in 64; dc_size in 2; dc_response out 4; dc_rdata out 64; dc_rtag out 4.
REQ-006 SHALL have memory-side ports: proc2mem_command out 2; proc2mem_addr out XLEN; proc2mem_data out 64; proc2mem_size out 2; mem2proc_response in 4; mem2proc_data in 64; mem2proc_tag in 4.
REQ-007 SHALL have status ports: ic_outstanding out 5; dc_outstanding out 5; spurious_tag out 1 (sticky error).

Function
REQ-008 SHALL forward exactly one requester per cycle to the memory side; with no request, proc2mem_command=NONE, addr/data=0.
REQ-009 SHALL grant dcache when both request, unless starve_cnt>=STARVE_LIMIT, then icache.
REQ-010 starve_cnt (3 bits, saturating) SHALL increment each cycle icache requests and is not granted or is granted but mem2proc_response=0; SHALL clear on any accepted icache request.
REQ-011 A grant SHALL be accepted iff mem2proc_response!=0 in the same cycle; the granted requester SHALL see mem2proc_response on its *_response, the other requester SHALL see 0 and must retry.
REQ-012 icache STORE commands SHALL be treated as NONE (never forwarded).
REQ-013 proc2mem_data and proc2mem_size SHALL carry dc_wdata/dc_size on a dcache grant; 0 data and size 2 (word) on an icache grant.
REQ-014 SHALL hold a 16-entry owner table (valid bit, owner bit: 0=icache, 1=dcache) indexed by tag; an accepted LOAD SHALL set entry[response] valid with owner at the clock edge.
REQ-015 Accepted STOREs SHALL NOT allocate a table entry.
REQ-016 When mem2proc_tag!=0 and entry[tag] valid: the owner's *_rtag SHALL equal mem2proc_tag and *_rdata=mem2proc_data in that cycle (combinational); the other's rtag=0; entry cleared at the edge.
REQ-017 When mem2proc_tag!=0 and entry invalid: no rtag SHALL be driven to either requester and spurious_tag SHALL set and hold until reset.
REQ-018 If the same tag is returned and re-allocated in one cycle, return SHALL be routed using the old entry and the new allocation SHALL win at the edge (entry valid, new owner).
REQ-019 ic_outstanding/dc_outstanding SHALL equal the count of valid entries per owner, updated at the edge; allocation and return for the same owner in one cycle SHALL net zero.
REQ-020 rdata outputs SHALL be 0 whenever the corresponding rtag is 0.
REQ-021 Tag 0 SHALL never be allocated and returns of tag 0 SHALL be ignored.

Reset
REQ-022 reset_n low SHALL asynchronously clear all table entries, starve_cnt, outstanding counters and spurious_tag; command/response outputs are combinational and reflect inputs with the cleared state.
REQ-023 A data return arriving after reset for a pre-reset tag SHALL be treated as spurious per REQ-017.

Verification
REQ-024 Both request LOAD, starve_cnt=0, mem response=3 -> dc_response=3, ic_response=0, entry3 valid owner=1, dc_outstanding=1.
REQ-025 icache denied 4 consecutive cycles while dcache requests -> 5th cycle icache granted; accepted with response=5 -> starve_cnt=0, ic_outstanding=1.
REQ-026 entry7 owner icache, mem2proc_tag=7 data=0xDEADBEEF_0000_1234 -> ic_rtag=7, ic_rdata=that value, dc_rtag=0, next cycle entry7 invalid.
REQ-027 mem2proc_tag=9 with entry9 invalid -> ic_rtag=dc_rtag=0, spurious_tag=1 held until reset_n low.
REQ-028 Tag 4 returned to icache while dcache LOAD accepted with response=4 same cycle -> ic_rtag=4, next cycle entry4 owner=1, ic_outstanding decremented, dc_outstanding incremented.
REQ-029 reset_n pulsed low mid-cycle with 3 outstanding loads -> immediately outstanding=0, spurious_tag=0; later tag return for old tag -> spurious_tag=1.
